rtc_digit_scanner: RTL and testbench
====================================

# rtc_digit_scanner

Time-multiplexed six-digit seven-segment driver that sits directly downstream of the real-time clock core. Takes the six decoded segment patterns (HH:MM:SS) plus per-digit decimal-point requests and drives one shared segment bus and six digit-enable lines, one digit at a time. Includes a dead-time (blanking) slot between digits to suppress ghosting, and per-frame input snapshots to prevent tearing.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit is lit; must be ≥1.
- `BLANK_CYCLES`, 500: dead-time cycles after each digit; 0 means no blanking slot.
- `SEG_ACTIVE_LOW`, 1: 1 inverts `seg_out` and `dp_out` at the pins.
- `DIG_ACTIVE_LOW`, 1: 1 inverts `dig_sel` at the pins.
---
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  scan enable; low forces all digits off.
- `seg_hr_m`, `seg_hr_l`, `seg_min_m`, `seg_min_l`, `seg_sec_m`, `seg_sec_l`  in  7 each  active-high segment patterns; bit6=a … bit0=g.
- `dp_mask`  in  6  per-digit decimal point request; bit i maps to digit i.
- `seg_out`  out  7  shared segment bus; bit6=a … bit0=g.
- `dp_out`  out  1  shared decimal point.
- `dig_sel`  out  6  digit enables; bit0=hr_m (leftmost) … bit5=sec_l.
- `frame_done`  out  1  one-cycle pulse when a full six-digit frame completes.

## Operation
- States: IDLE, SHOW, BLANK. Registers: 3-bit digit index `idx` (0..5), timer, 42-bit segment snapshot, 6-bit dp snapshot.
- IDLE: all outputs off. On `en`=1:
  - latch the snapshot from the current inputs;
  - set `idx`=0 and load the timer with REFRESH_DIV;
  - go to SHOW.
- SHOW: `dig_sel` is one-hot at `idx`; `seg_out` and `dp_out` come from the snapshot entry for `idx`. After exactly REFRESH_DIV cycles:
  - go to BLANK if BLANK_CYCLES>0;
  - otherwise advance directly (same rules as the end of BLANK).
- BLANK: digits off, segments off, for exactly BLANK_CYCLES cycles. Then advance:
  - `idx`<5: `idx`+1, enter SHOW.
  - `idx`=5: wrap to 0, re-latch the snapshot, pulse `frame_done`, enter SHOW.
- Snapshot:
  - Taken only on entry to digit 0.
  - Input changes mid-frame are invisible until the next frame.
- `en` deasserted in any state: IDLE on the next edge, all outputs off on that edge; no `frame_done`.
- "Off" at the pins, after polarity parameters are applied:
  - `dig_sel` = 6'h3F when DIG_ACTIVE_LOW=1, else 0;
  - `seg_out` = 7'h7F and `dp_out`=1 when SEG_ACTIVE_LOW=1, else 0.
- Reset (`reset`=0 sampled at an edge) from any state, including mid-digit:
  - state IDLE, `idx` 0, timer 0, snapshot 0;
  - all outputs at "off" levels; `frame_done`=0.
- Timer width: $clog2(max(REFRESH_DIV, BLANK_CYCLES)+1). It down-counts and never wraps.

## Timing
- All outputs are registered and change only on `clk` rising edges.
- Latency from `en` to display: `en` sampled high at edge N → `dig_sel` shows digit 0 from edge N+1.
- Slot lengths: each SHOW is exactly REFRESH_DIV cycles; each BLANK is exactly BLANK_CYCLES cycles.
- Frame period is 6·(REFRESH_DIV+BLANK_CYCLES) cycles.
- `frame_done`:
  - high for exactly one cycle, coincident with the first cycle of the next digit-0 SHOW;
  - never asserted on the initial start from IDLE.
- Break-before-make:
  - at most one `dig_sel` bit is active in any cycle;
  - `seg_out` never changes while a digit is lit except on the SHOW-entry edge, when `dig_sel` changes simultaneously.
- Priority when events coincide: reset > `en` low > timer expiry.

## Structure
- Shared package `rtc_pkg`:
  - `NUM_DIGITS`=6 and `SEG_W`=7;
  - the digit-index constants (`DIG_HR_M` … `DIG_SEC_L`);
  - the scan-state enum type.
- One sub-module, `scan_timer`: a loadable down-counter with a `load`/`value`/`expired` interface, reset synchronous active-low. The scanner FSM instantiates it once.
- Polarity inversion is applied at the output registers only; internal logic is active-high.

## Test plan
- Reset and idle:
  - Stimulus: REFRESH_DIV=4, BLANK_CYCLES=2, `en`=0, release reset.
  - Required: `dig_sel`=6'h3F, `seg_out`=7'h7F, `dp_out`=1, `frame_done`=0, held for 20 cycles.
- Scan order and slot lengths:
  - Stimulus: same parameters, `en`=1, segment inputs 7'h7E,7'h30,7'h6D,7'h79,7'h33,7'h5B, `dp_mask`=6'b000100.
  - Required digit sequence: `dig_sel` 6'h3E for 4 cycles, all-off for 2, then 6'h3D, …, 6'h1F.
  - Required segments: `seg_out`=~pattern for each digit; `dp_out`=0 only for digit 2.
  - Required pulse: `frame_done` at cycle 37 after `en`; period 36.
- Snapshot isolation:
  - Stimulus: change `seg_sec_l` to 7'h7F during digit 1.
  - Required: digit 5 still shows the old value; the new value appears only in the next frame.
- No-blank mode:
  - Stimulus: BLANK_CYCLES=0.
  - Required: digits back-to-back, each 4 cycles; frame period 24; never two `dig_sel` bits active.
- Mid-operation abort:
  - Stimulus: `en` low during digit 3, then high again.
  - Required: all off next edge, no `frame_done`; restart at digit 0 with a fresh snapshot.
  - Stimulus: repeat the abort using `reset`=0 instead of `en`.
  - Required: same result, with all state cleared.
- Polarity:
  - Stimulus: SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0.
  - Required: idle outputs are all 0; a lit digit 0 gives `dig_sel`=6'h01 and `seg_out` equal to the raw pattern.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared constants and types for the six-digit RTC display scanner.
package rtc_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = 3;

    // Digit positions, leftmost first.
    localparam int unsigned DIG_HR_M  = 0;
    localparam int unsigned DIG_HR_L  = 1;
    localparam int unsigned DIG_MIN_M = 2;
    localparam int unsigned DIG_MIN_L = 3;
    localparam int unsigned DIG_SEC_M = 4;
    localparam int unsigned DIG_SEC_L = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    typedef logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_snap_t;

    // One display drive word, active-high inside the scanner.
    typedef struct packed {
        logic [SEG_W-1:0]      seg;
        logic                  dp;
        logic [NUM_DIGITS-1:0] dig;
        logic                  frame_done;
    } scan_out_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Loadable saturating down-counter; expired_c flags the last cycle of a loaded slot.
module scan_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         expired_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A slot loaded with N ends on the edge where the count has reached 1.
    assign expired_c = (count_q <= W'(1));

endmodule

// File: rtl/rtc_digit_scanner.sv
// Time-multiplexed six-digit seven-segment driver with blanking slots and
// per-frame snapshots of the segment inputs.
module rtc_digit_scanner
    import rtc_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 50000,
    parameter int unsigned BLANK_CYCLES   = 500,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [SEG_W-1:0]      seg_hr_m,
    input  logic [SEG_W-1:0]      seg_hr_l,
    input  logic [SEG_W-1:0]      seg_min_m,
    input  logic [SEG_W-1:0]      seg_min_l,
    input  logic [SEG_W-1:0]      seg_sec_m,
    input  logic [SEG_W-1:0]      seg_sec_l,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [SEG_W-1:0]      seg_out,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  frame_done
);

    localparam int unsigned TMR_MAX = max_u(REFRESH_DIV, BLANK_CYCLES);
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]      SHOW_LOAD  = TMR_W'(REFRESH_DIV);
    localparam logic [TMR_W-1:0]      BLANK_LOAD = TMR_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]      SEG_OFF    = {SEG_W{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW}};

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    seg_snap_t             snap_seg_q, snap_seg_d;
    logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic                  wrap_q, wrap_d;

    seg_snap_t             live_seg_c;
    logic                  advance_c;
    logic                  tmr_load_c;
    logic [TMR_W-1:0]      tmr_val_c;
    logic                  tmr_expired_c;

    scan_out_t             drive_c;
    scan_out_t             pins_q;

    assign live_seg_c = {seg_sec_l, seg_sec_m, seg_min_l, seg_min_m, seg_hr_l, seg_hr_m};

    scan_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (tmr_load_c),
        .value_i   (tmr_val_c),
        .expired_c (tmr_expired_c)
    );

    // Next-state: en low beats slot expiry; frame wrap re-latches the snapshot.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_seg_d = snap_seg_q;
        snap_dp_d  = snap_dp_q;
        wrap_d     = 1'b0;
        advance_c  = 1'b0;
        tmr_load_c = 1'b0;
        tmr_val_c  = SHOW_LOAD;

        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    snap_seg_d = live_seg_c;
                    snap_dp_d  = dp_mask;
                    idx_d      = '0;
                    tmr_load_c = 1'b1;
                    state_d    = ST_SHOW;
                end
                ST_SHOW: begin
                    if (tmr_expired_c) begin
                        if (BLANK_CYCLES != 0) begin
                            state_d    = ST_BLANK;
                            tmr_load_c = 1'b1;
                            tmr_val_c  = BLANK_LOAD;
                        end else begin
                            advance_c = 1'b1;
                        end
                    end
                end
                ST_BLANK: begin
                    if (tmr_expired_c) begin
                        advance_c = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (advance_c) begin
                state_d    = ST_SHOW;
                tmr_load_c = 1'b1;
                tmr_val_c  = SHOW_LOAD;
                if (idx_q == LAST_IDX) begin
                    idx_d      = '0;
                    snap_seg_d = live_seg_c;
                    snap_dp_d  = dp_mask;
                    wrap_d     = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            snap_seg_q <= '0;
            snap_dp_q  <= '0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_seg_q <= snap_seg_d;
            snap_dp_q  <= snap_dp_d;
            wrap_q     <= wrap_d;
        end
    end

    // Display drive follows the current slot; en low blanks on the same edge.
    always_comb begin
        drive_c = '0;
        if (en && (state_q == ST_SHOW)) begin
            drive_c.seg        = snap_seg_q[idx_q];
            drive_c.dp         = snap_dp_q[idx_q];
            drive_c.dig        = NUM_DIGITS'(1) << idx_q;
            drive_c.frame_done = wrap_q;
        end
    end

    // Pin polarity is applied only here.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pins_q.seg        <= SEG_OFF;
            pins_q.dp         <= SEG_ACTIVE_LOW;
            pins_q.dig        <= DIG_OFF;
            pins_q.frame_done <= 1'b0;
        end else begin
            pins_q.seg        <= drive_c.seg ^ SEG_OFF;
            pins_q.dp         <= drive_c.dp ^ SEG_ACTIVE_LOW;
            pins_q.dig        <= drive_c.dig ^ DIG_OFF;
            pins_q.frame_done <= drive_c.frame_done;
        end
    end

    assign seg_out    = pins_q.seg;
    assign dp_out     = pins_q.dp;
    assign dig_sel    = pins_q.dig;
    assign frame_done = pins_q.frame_done;

endmodule

// File: tb/tb_rtc_digit_scanner.sv
// Bench for rtc_digit_scanner: three parameterisations checked cycle by cycle
// against a slot-position model of the scan schedule.
module tb_rtc_digit_scanner;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic [2:0] rst_b;
    logic [2:0] en_b;
    logic [6:0] seg_in [6];
    logic [5:0] dp_in;

    logic [6:0] so0, so1, so2;
    logic       dpo0, dpo1, dpo2;
    logic [5:0] dgo0, dgo1, dgo2;
    logic       fdo0, fdo1, fdo2;

    int vectors    = 0;
    int miscompares = 0;

    logic [6:0] m_seg [6];
    logic [5:0] m_dp;
    logic [6:0] seg_hist [256];
    logic [5:0] dig_hist [256];
    int         fd_first;
    int         fd_second;

    always #5 clk = ~clk;

    rtc_digit_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut0 (
        .clk(clk), .reset(rst_b[0]), .en(en_b[0]),
        .seg_hr_m(seg_in[0]), .seg_hr_l(seg_in[1]), .seg_min_m(seg_in[2]),
        .seg_min_l(seg_in[3]), .seg_sec_m(seg_in[4]), .seg_sec_l(seg_in[5]),
        .dp_mask(dp_in), .seg_out(so0), .dp_out(dpo0), .dig_sel(dgo0), .frame_done(fdo0));

    rtc_digit_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) u_dut1 (
        .clk(clk), .reset(rst_b[1]), .en(en_b[1]),
        .seg_hr_m(seg_in[0]), .seg_hr_l(seg_in[1]), .seg_min_m(seg_in[2]),
        .seg_min_l(seg_in[3]), .seg_sec_m(seg_in[4]), .seg_sec_l(seg_in[5]),
        .dp_mask(dp_in), .seg_out(so1), .dp_out(dpo1), .dig_sel(dgo1), .frame_done(fdo1));

    rtc_digit_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) u_dut2 (
        .clk(clk), .reset(rst_b[2]), .en(en_b[2]),
        .seg_hr_m(seg_in[0]), .seg_hr_l(seg_in[1]), .seg_min_m(seg_in[2]),
        .seg_min_l(seg_in[3]), .seg_sec_m(seg_in[4]), .seg_sec_l(seg_in[5]),
        .dp_mask(dp_in), .seg_out(so2), .dp_out(dpo2), .dig_sel(dgo2), .frame_done(fdo2));

    function automatic int blank_of(input int i);
        return (i == 1) ? 0 : 2;
    endfunction

    function automatic bit low_of(input int i);
        return (i == 2) ? 1'b0 : 1'b1;
    endfunction

    task automatic get_out(input int i, output logic [6:0] s, output logic d,
                           output logic [5:0] g, output logic f);
        case (i)
            0:       begin s = so0; d = dpo0; g = dgo0; f = fdo0; end
            1:       begin s = so1; d = dpo1; g = dgo1; f = fdo1; end
            default: begin s = so2; d = dpo2; g = dgo2; f = fdo2; end
        endcase
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 6; k++) seg_in[k] = 7'($urandom);
        dp_in = 6'($urandom);
    endtask

    // Start a scan on instance inst and check every edge against the schedule.
    task automatic run_scan(input int inst, input int ncyc, input bit rnd_mut,
                            input int mut_at, input int abort_at, input bit abort_rst);
        int per, slot, p, d;
        bit lit, cap;
        logic [6:0] tmp_seg [6];
        logic [5:0] tmp_dp;
        logic [6:0] es, as_, off_s;
        logic       ed, ad, ef, af, off_d;
        logic [5:0] eg, ag, off_g, ah;
        slot  = RD + blank_of(inst);
        per   = 6 * slot;
        off_s = low_of(inst) ? 7'h7F : 7'h00;
        off_d = low_of(inst);
        off_g = low_of(inst) ? 6'h3F : 6'h00;
        fd_first  = -1;
        fd_second = -1;
        @(negedge clk);
        en_b[inst]  = 1'b1;
        rst_b[inst] = 1'b1;
        for (int j = 0; j <= ncyc; j++) begin
            cap = ((j % per) == 0);
            if (cap) begin
                tmp_seg = seg_in;
                tmp_dp  = dp_in;
            end
            @(posedge clk);
            @(negedge clk);
            lit = 1'b0; d = 0; ef = 1'b0;
            if (j >= 1) begin
                p   = (j - 1) % per;
                d   = p / slot;
                lit = (p % slot) < RD;
                ef  = ((j - 1) >= per) && (p == 0);
            end
            es = lit ? m_seg[d] : 7'h00;
            ed = lit ? m_dp[d] : 1'b0;
            eg = lit ? 6'(1 << d) : 6'h00;
            es = es ^ off_s;
            ed = ed ^ off_d;
            eg = eg ^ off_g;
            get_out(inst, as_, ad, ag, af);
            vectors++;
            if ({as_, ad, ag, af} !== {es, ed, eg, ef}) begin
                miscompares++;
                $display("FAIL scan inst%0d cycle %0d: got seg=%h dp=%b dig=%h fd=%b, want seg=%h dp=%b dig=%h fd=%b",
                         inst, j, as_, ad, ag, af, es, ed, eg, ef);
            end
            ah = ag ^ off_g;
            vectors++;
            if ($countones(ah) > 1) begin
                miscompares++;
                $display("FAIL one_hot inst%0d cycle %0d: got dig=%h, want at most one active", inst, j, ag);
            end
            if (j < 256) begin
                seg_hist[j] = as_;
                dig_hist[j] = ag;
            end
            if (af === 1'b1) begin
                if (fd_first < 0) fd_first = j;
                else if (fd_second < 0) fd_second = j;
            end
            if (cap) begin
                m_seg = tmp_seg;
                m_dp  = tmp_dp;
            end
            if (j == abort_at) begin
                if (abort_rst) rst_b[inst] = 1'b0;
                else en_b[inst] = 1'b0;
                randomize_inputs();
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    get_out(inst, as_, ad, ag, af);
                    vectors++;
                    if ({as_, ad, ag, af} !== {off_s, off_d, off_g, 1'b0}) begin
                        miscompares++;
                        $display("FAIL abort_off inst%0d +%0d: got seg=%h dp=%b dig=%h fd=%b, want seg=%h dp=%b dig=%h fd=0",
                                 inst, k, as_, ad, ag, af, off_s, off_d, off_g);
                    end
                end
                return;
            end
            if (j == mut_at) begin
                seg_in[5] = 7'h7F;
            end else if (rnd_mut && ($urandom_range(2) == 0)) begin
                seg_in[$urandom_range(4)] = 7'($urandom);
                dp_in = 6'($urandom);
            end
        end
        en_b[inst] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        get_out(inst, as_, ad, ag, af);
        vectors++;
        if ({as_, ad, ag, af} !== {off_s, off_d, off_g, 1'b0}) begin
            miscompares++;
            $display("FAIL stop_off inst%0d: got seg=%h dp=%b dig=%h fd=%b, want seg=%h dp=%b dig=%h fd=0",
                     inst, as_, ad, ag, af, off_s, off_d, off_g);
        end
    endtask

    task automatic test_reset();
        logic [6:0] s;
        logic       d, f;
        logic [5:0] g;
        rst_b = 3'b000;
        en_b  = 3'b000;
        randomize_inputs();
        repeat (3) @(negedge clk);
        rst_b = 3'b111;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((c % 5) == 0) randomize_inputs();
            for (int i = 0; i < 3; i++) begin
                get_out(i, s, d, g, f);
                vectors++;
                if ({s, d, g, f} !== (low_of(i) ? {7'h7F, 1'b1, 6'h3F, 1'b0} : 15'h0)) begin
                    miscompares++;
                    $display("FAIL reset_idle inst%0d cycle %0d: got seg=%h dp=%b dig=%h fd=%b", i, c, s, d, g, f);
                end
            end
        end
    endtask

    task automatic test_scan_order();
        seg_in[0] = 7'h7E; seg_in[1] = 7'h30; seg_in[2] = 7'h6D;
        seg_in[3] = 7'h79; seg_in[4] = 7'h33; seg_in[5] = 7'h5B;
        dp_in = 6'b000100;
        run_scan(0, 80, 1'b0, -1, -1, 1'b0);
        vectors++;
        if (fd_first != 37 || (fd_second - fd_first) != 36) begin
            miscompares++;
            $display("FAIL frame_timing: got first=%0d second=%0d, want 37 and 73", fd_first, fd_second);
        end
        vectors++;
        if (seg_hist[13] !== 7'h12 || dig_hist[13] !== 6'h3B) begin
            miscompares++;
            $display("FAIL digit2_drive: got seg=%h dig=%h, want seg=12 dig=3b", seg_hist[13], dig_hist[13]);
        end
    endtask

    task automatic test_snapshot();
        randomize_inputs();
        seg_in[5] = 7'h06;
        run_scan(0, 80, 1'b1, 8, -1, 1'b0);
        vectors++;
        if (seg_hist[31] !== 7'h79 || dig_hist[31] !== 6'h1F) begin
            miscompares++;
            $display("FAIL snapshot_old: got seg=%h dig=%h, want seg=79 dig=1f", seg_hist[31], dig_hist[31]);
        end
        vectors++;
        if (seg_hist[67] !== 7'h00 || dig_hist[67] !== 6'h1F) begin
            miscompares++;
            $display("FAIL snapshot_new: got seg=%h dig=%h, want seg=00 dig=1f", seg_hist[67], dig_hist[67]);
        end
    endtask

    task automatic test_no_blank();
        randomize_inputs();
        run_scan(1, 60, 1'b1, -1, -1, 1'b0);
        vectors++;
        if (fd_first != 25 || fd_second != 49) begin
            miscompares++;
            $display("FAIL no_blank_period: got first=%0d second=%0d, want 25 and 49", fd_first, fd_second);
        end
        vectors++;
        if (dig_hist[4] !== 6'h3E || dig_hist[5] !== 6'h3D) begin
            miscompares++;
            $display("FAIL no_blank_handoff: got %h then %h, want 3e then 3d", dig_hist[4], dig_hist[5]);
        end
    endtask

    task automatic test_abort();
        randomize_inputs();
        run_scan(0, 40, 1'b1, -1, 20, 1'b0);
        randomize_inputs();
        run_scan(0, 45, 1'b1, -1, -1, 1'b0);
        randomize_inputs();
        run_scan(0, 40, 1'b1, -1, 21, 1'b1);
        randomize_inputs();
        run_scan(0, 45, 1'b1, -1, -1, 1'b0);
    endtask

    task automatic test_polarity();
        randomize_inputs();
        seg_in[0] = 7'h5A;
        run_scan(2, 80, 1'b1, -1, -1, 1'b0);
        vectors++;
        if (seg_hist[1] !== 7'h5A || dig_hist[1] !== 6'h01) begin
            miscompares++;
            $display("FAIL polarity_lit: got seg=%h dig=%h, want seg=5a dig=01", seg_hist[1], dig_hist[1]);
        end
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_snapshot();
        test_no_blank();
        test_abort();
        test_polarity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
